// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and default geometry for the SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 4;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Width-independent part of a latched operation; the addr/wdata fields
    // are added by the arbiter at its own parameterised geometry.
    typedef struct packed {
        logic id;
        logic we;
    } op_ctrl_t;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant; ptr selects the winner on a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Round-robin arbiter serialising two requesters onto one SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                sram_en,
    output logic                sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam logic [2:0] c_RD_LAT = 3'(RD_LAT);

    typedef struct packed {
        op_ctrl_t          ctrl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } op_t;

    state_t              r_state,      w_state_nxt;
    op_t                 r_op,         w_op_nxt;
    logic                r_rr_ptr,     w_rr_ptr_nxt;
    logic [2:0]          r_wait_cnt,   w_wait_cnt_nxt;
    logic [1:0]          r_rsp_valid,  w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata,  w_rsp_rdata_nxt;
    logic                r_sram_en,    w_sram_en_nxt;
    logic                r_sram_we,    w_sram_we_nxt;
    logic [ADDR_W-1:0]   r_sram_addr,  w_sram_addr_nxt;
    logic [DATA_W-1:0]   r_sram_wdata, w_sram_wdata_nxt;

    logic [1:0]          w_gnt;
    logic                w_hs;
    logic                w_hs_id;
    op_t                 w_req_op;

    rr_arb2 u_rr_arb2 (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .gnt (w_gnt)
    );

    assign req_ready = (r_state == S_IDLE && !rst) ? w_gnt : 2'b00;
    assign w_hs      = |(req_valid & req_ready);
    assign w_hs_id   = req_ready[1];

    always_comb begin
        w_req_op.ctrl.id = w_hs_id;
        w_req_op.ctrl.we = w_hs_id ? req_we[1] : req_we[0];
        w_req_op.addr    = w_hs_id ? req_addr[2*ADDR_W-1:ADDR_W]
                                   : req_addr[ADDR_W-1:0];
        w_req_op.wdata   = w_hs_id ? req_wdata[2*DATA_W-1:DATA_W]
                                   : req_wdata[DATA_W-1:0];
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_rsp_valid_nxt  = 2'b00;
        w_rsp_rdata_nxt  = r_rsp_rdata;
        w_sram_en_nxt    = 1'b0;
        w_sram_we_nxt    = 1'b0;
        w_sram_addr_nxt  = '0;
        w_sram_wdata_nxt = '0;

        case (r_state)
            S_IDLE: begin
                w_rsp_rdata_nxt = '0;
                if (w_hs) begin
                    w_op_nxt         = w_req_op;
                    w_rr_ptr_nxt     = ~w_hs_id;
                    w_state_nxt      = S_ACCESS;
                    // SRAM pins are registered, so they are loaded on entry
                    // to ACCESS to be valid during that single cycle.
                    w_sram_en_nxt    = 1'b1;
                    w_sram_we_nxt    = w_req_op.ctrl.we;
                    w_sram_addr_nxt  = w_req_op.addr;
                    w_sram_wdata_nxt = w_req_op.wdata;
                end
            end
            S_ACCESS: begin
                if (r_op.ctrl.we) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = r_op.ctrl.id ? 2'b10 : 2'b01;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = c_RD_LAT;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt - 3'd1;
                if (r_wait_cnt == 3'd1) begin
                    w_rsp_rdata_nxt = sram_rdata;
                    w_rsp_valid_nxt = r_op.ctrl.id ? 2'b10 : 2'b01;
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_rdata_nxt = '0;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_rr_ptr     <= 1'b0;
            r_wait_cnt   <= 3'd0;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_sram_en    <= w_sram_en_nxt;
            r_sram_we    <= w_sram_we_nxt;
            r_sram_addr  <= w_sram_addr_nxt;
            r_sram_wdata <= w_sram_wdata_nxt;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Scoreboard bench for sram_arbiter at RD_LAT 1 and RD_LAT 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      req_valid [2];
    logic [1:0]      req_ready [2];
    logic [1:0]      req_we    [2];
    logic [2*AW-1:0] req_addr  [2];
    logic [2*DW-1:0] req_wdata [2];
    logic [1:0]      rsp_valid [2];
    logic [DW-1:0]   rsp_rdata [2];
    logic            sram_en   [2];
    logic            sram_we   [2];
    logic [AW-1:0]   sram_addr [2];
    logic [DW-1:0]   sram_wdata[2];
    logic [DW-1:0]   sram_rdata[2];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            sram_arbiter #(
                .ADDR_W (AW),
                .DATA_W (DW),
                .RD_LAT ((g == 0) ? 1 : 3)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (req_valid[g]),
                .req_ready  (req_ready[g]),
                .req_we     (req_we[g]),
                .req_addr   (req_addr[g]),
                .req_wdata  (req_wdata[g]),
                .rsp_valid  (rsp_valid[g]),
                .rsp_rdata  (rsp_rdata[g]),
                .sram_en    (sram_en[g]),
                .sram_we    (sram_we[g]),
                .sram_addr  (sram_addr[g]),
                .sram_wdata (sram_wdata[g]),
                .sram_rdata (sram_rdata[g])
            );
        end
    endgenerate

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // SRAM models: read data emerges RD_LAT cycles after the access cycle.
    logic [DW-1:0] mem  [2][16];
    logic [DW-1:0] pipe [2][3];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pipe[k][2] <= pipe[k][1];
            pipe[k][1] <= pipe[k][0];
            pipe[k][0] <= '0;
            if (sram_en[k] && sram_we[k]) mem[k][sram_addr[k]] <= sram_wdata[k];
            if (sram_en[k] && !sram_we[k]) pipe[k][0] <= mem[k][sram_addr[k]];
        end
    end
    assign sram_rdata[0] = pipe[0][0];
    assign sram_rdata[1] = pipe[1][2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            inst;
        int            id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t          acc_q [$];
    exp_t          rsp_q [$];
    int            grants[$];
    logic [DW-1:0] smem  [2][16];
    bit            busy  [2];
    int            errors = 0;
    int            checks = 0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] hs;
        int         id;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k] = 1'b0;
                acc_q.delete();
                rsp_q.delete();
            end else if (busy[k]) begin
                check($sformatf("ready_while_busy[%0d]", k), req_ready[k], 0);
            end

            if (!sram_en[k]) begin
                check($sformatf("sram_idle_zero[%0d]", k),
                      {sram_we[k], sram_addr[k], sram_wdata[k]}, 0);
            end else if (acc_q.size() == 0) begin
                check($sformatf("unexpected_access[%0d]", k), 1, 0);
            end else begin
                e = acc_q.pop_front();
                check($sformatf("access_inst[%0d]", k), k, e.inst);
                check($sformatf("access_cycle[%0d]", k), cyc, e.cyc);
                check($sformatf("access_we[%0d]", k), sram_we[k], e.we);
                check($sformatf("access_addr[%0d]", k), sram_addr[k], e.addr);
                check($sformatf("access_wdata[%0d]", k), sram_wdata[k], e.wdata);
            end

            if (rsp_valid[k] == 2'b00) begin
                check($sformatf("rdata_idle_zero[%0d]", k), rsp_rdata[k], 0);
            end else if (rsp_q.size() == 0) begin
                check($sformatf("unexpected_rsp[%0d]", k), rsp_valid[k], 0);
            end else begin
                e = rsp_q.pop_front();
                check($sformatf("rsp_inst[%0d]", k), k, e.inst);
                check($sformatf("rsp_valid[%0d]", k), rsp_valid[k], (e.id == 1) ? 2 : 1);
                check($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], e.rdata);
                check($sformatf("rsp_cycle[%0d]", k), cyc, e.cyc);
                busy[k] = 1'b0;
            end

            hs = req_valid[k] & req_ready[k];
            if (hs != 2'b00) begin
                check($sformatf("grant_onehot[%0d]", k), (hs == 2'b11), 0);
                check($sformatf("grant_when_busy[%0d]", k), busy[k], 0);
                id      = hs[1] ? 1 : 0;
                e.inst  = k;
                e.id    = id;
                e.we    = req_we[k][id];
                e.addr  = req_addr[k][id*AW +: AW];
                e.wdata = req_wdata[k][id*DW +: DW];
                e.rdata = e.we ? '0 : smem[k][e.addr];
                e.cyc   = cyc + 1;
                acc_q.push_back(e);
                e.cyc   = cyc + 2 + (e.we ? 0 : lat(k));
                rsp_q.push_back(e);
                if (e.we) smem[k][e.addr] = e.wdata;
                grants.push_back(id);
                busy[k] = 1'b1;
            end
        end
    end

    task automatic set_req(int k, int id, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        req_we[k][id]             = we;
        req_addr[k][id*AW +: AW]  = a;
        req_wdata[k][id*DW +: DW] = d;
        req_valid[k][id]          = 1'b1;
    endtask

    task automatic wait_hs(int k, int id);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_valid[k][id] && req_ready[k][id]) ok = 1'b1;
        end
        check($sformatf("handshake_timeout[%0d][%0d]", k, id), ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(int k);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            if (!busy[k]) ok = 1'b1;
        end
        check($sformatf("idle_timeout[%0d]", k), ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_req(int k, int id, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        set_req(k, id, we, a, d);
        wait_hs(k, id);
        req_valid[k][id] = 1'b0;
        wait_idle(k);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_outputs_zero(int k, string tag);
        check($sformatf("%s_req_ready[%0d]", tag, k), req_ready[k], 0);
        check($sformatf("%s_rsp_valid[%0d]", tag, k), rsp_valid[k], 0);
        check($sformatf("%s_rsp_rdata[%0d]", tag, k), rsp_rdata[k], 0);
        check($sformatf("%s_sram[%0d]", tag, k),
              {sram_en[k], sram_we[k], sram_addr[k], sram_wdata[k]}, 0);
    endtask

    initial begin
        bit ok;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0;
            req_we[k]    = '0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end

        // Reset state, with requests pending to show ready is held off
        req_valid[0] = 2'b11;
        req_valid[1] = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero(0, "reset");
        check_outputs_zero(1, "reset");
        @(posedge clk); #1;
        req_valid[0] = 2'b00;
        req_valid[1] = 2'b00;
        rst = 1'b0;

        // Single write, then read back by the other requester
        do_req(0, 0, 1'b1, 4'd3, 8'hA5);
        do_req(0, 1, 1'b0, 4'd3, 8'h00);

        // Both requesters continuously valid: alternating grants
        pulse_reset();
        grants.delete();
        set_req(0, 0, 1'b1, 4'd1, 8'h10);
        set_req(0, 1, 1'b1, 4'd2, 8'h20);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (grants.size() >= 4) ok = 1'b1;
        end
        check("four_grants_timeout", ok, 1);
        @(posedge clk); #1;
        req_valid[0] = 2'b00;
        wait_idle(0);
        check("grant_count", grants.size(), 4);
        if (grants.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("grant_order[%0d]", i), grants[i], i % 2);
        end

        // Address changed while the FSM is busy: handshake value must win
        set_req(0, 1, 1'b0, 4'd1, 8'h00);
        wait_hs(0, 1);
        req_valid[0][1] = 1'b0;
        set_req(0, 0, 1'b1, 4'd5, 8'h11);
        @(posedge clk); #1;
        req_addr[0][AW-1:0] = 4'd9;
        wait_hs(0, 0);
        req_valid[0][0] = 1'b0;
        wait_idle(0);
        do_req(0, 1, 1'b0, 4'd9, 8'h00);

        // Reset during WAIT of a read from requester 0
        set_req(0, 0, 1'b0, 4'd3, 8'h00);
        wait_hs(0, 0);
        req_valid[0][0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 0, 1'b1, 4'd4, 8'h44);
        set_req(0, 1, 1'b1, 4'd6, 8'h66);
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero(0, "midop_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        grants.delete();
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (grants.size() >= 1) ok = 1'b1;
        end
        check("post_reset_grant_timeout", ok, 1);
        if (grants.size() >= 1) check("post_reset_grant", grants[0], 0);
        @(posedge clk); #1;
        req_valid[0] = 2'b00;
        wait_idle(0);

        // RD_LAT = 3 instance: write 0x3C, then read with the peer pending
        do_req(1, 0, 1'b1, 4'd0, 8'h3C);
        set_req(1, 0, 1'b0, 4'd0, 8'h00);
        wait_hs(1, 0);
        req_valid[1][0] = 1'b0;
        set_req(1, 1, 1'b0, 4'd0, 8'h00);
        wait_hs(1, 1);
        req_valid[1][1] = 1'b0;
        wait_idle(1);

        repeat (3) @(posedge clk);
        check("access_queue_drained", acc_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule : tb_sram_arbiter
`default_nettype wire
